// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Word-wide request port toward the pipeline; line-wide (256-bit) port toward memory.
module dcache_dm_wb #(
    parameter int unsigned S_INDEX  = 3,
    parameter int unsigned S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned SETS   = 2 ** S_INDEX;
    localparam int unsigned TAG_W  = 32 - S_INDEX - S_OFFSET;
    localparam int unsigned LINE_W = 8 * (2 ** S_OFFSET);
    localparam int unsigned WSEL_W = S_OFFSET - 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESP      = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_FILL      = 2'd3
    } state_t;

    // Storage: valid/dirty are reset, tag/data are not
    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    state_t            r_state;
    logic              r_mem_resp;
    logic [31:0]       r_mem_rdata;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [31:0]       r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;

    // Address decode
    logic [TAG_W-1:0]   w_tag;
    logic [S_INDEX-1:0] w_index;
    logic [WSEL_W-1:0]  w_word;
    logic               w_unused;

    assign w_tag    = mem_address[31 -: TAG_W];
    assign w_index  = mem_address[S_OFFSET +: S_INDEX];
    assign w_word   = mem_address[2 +: WSEL_W];
    assign w_unused = &{1'b0, mem_address[1:0]};

    // Lookup, read-word select and byte-merge of the addressed line
    logic              w_hit;
    logic [LINE_W-1:0] w_cur_line;
    logic [31:0]       w_old_word;
    logic [31:0]       w_new_word;
    logic [LINE_W-1:0] w_merged_line;

    always_comb begin
        w_cur_line    = r_data[w_index];
        w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
        w_old_word    = w_cur_line[{w_word, 5'b0} +: 32];
        w_new_word    = w_old_word;
        for (int i = 0; i < 4; i++) begin
            if (mem_byte_enable[i]) begin
                w_new_word[8*i +: 8] = mem_wdata[8*i +: 8];
            end
        end
        w_merged_line = w_cur_line;
        w_merged_line[{w_word, 5'b0} +: 32] = w_new_word;
    end

    // Next-state and next-output values, plus array write controls
    state_t            w_state_nxt;
    logic              w_mem_resp;
    logic [31:0]       w_mem_rdata;
    logic              w_pmem_read;
    logic              w_pmem_write;
    logic [31:0]       w_pmem_address;
    logic [LINE_W-1:0] w_pmem_wdata;
    logic              w_data_we;
    logic [LINE_W-1:0] w_data_line;
    logic              w_tag_we;
    logic              w_set_valid;
    logic              w_set_dirty;
    logic              w_clr_dirty;

    always_comb begin
        w_state_nxt    = r_state;
        w_mem_resp     = 1'b0;
        w_mem_rdata    = r_mem_rdata;
        w_pmem_read    = 1'b0;
        w_pmem_write   = 1'b0;
        w_pmem_address = r_pmem_address;
        w_pmem_wdata   = r_pmem_wdata;
        w_data_we      = 1'b0;
        w_data_line    = pmem_rdata;
        w_tag_we       = 1'b0;
        w_set_valid    = 1'b0;
        w_set_dirty    = 1'b0;
        w_clr_dirty    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    if (w_hit) begin
                        // Simultaneous read+write is treated as a write
                        if (mem_write) begin
                            w_data_we   = 1'b1;
                            w_data_line = w_merged_line;
                            w_set_dirty = 1'b1;
                        end else begin
                            w_mem_rdata = w_old_word;
                        end
                        w_state_nxt = ST_RESP;
                        w_mem_resp  = 1'b1;
                    end else if (r_valid[w_index] && r_dirty[w_index]) begin
                        w_state_nxt    = ST_WRITEBACK;
                        w_pmem_write   = 1'b1;
                        w_pmem_address = {r_tag[w_index], w_index, S_OFFSET'(0)};
                        w_pmem_wdata   = w_cur_line;
                    end else begin
                        w_state_nxt    = ST_FILL;
                        w_pmem_read    = 1'b1;
                        w_pmem_address = {mem_address[31:S_OFFSET], S_OFFSET'(0)};
                    end
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            ST_WRITEBACK: begin
                w_pmem_write = 1'b1;
                if (pmem_resp) begin
                    w_clr_dirty    = 1'b1;
                    w_state_nxt    = ST_FILL;
                    w_pmem_write   = 1'b0;
                    w_pmem_read    = 1'b1;
                    w_pmem_address = {mem_address[31:S_OFFSET], S_OFFSET'(0)};
                end
            end
            ST_FILL: begin
                w_pmem_read = 1'b1;
                if (pmem_resp) begin
                    w_data_we   = 1'b1;
                    w_data_line = pmem_rdata;
                    w_tag_we    = 1'b1;
                    w_set_valid = 1'b1;
                    w_clr_dirty = 1'b1;
                    w_pmem_read = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and valid/dirty bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_mem_resp     <= 1'b0;
            r_mem_rdata    <= 32'd0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= 32'd0;
            r_pmem_wdata   <= LINE_W'(0);
            r_valid        <= SETS'(0);
            r_dirty        <= SETS'(0);
        end else begin
            r_state        <= w_state_nxt;
            r_mem_resp     <= w_mem_resp;
            r_mem_rdata    <= w_mem_rdata;
            r_pmem_read    <= w_pmem_read;
            r_pmem_write   <= w_pmem_write;
            r_pmem_address <= w_pmem_address;
            r_pmem_wdata   <= w_pmem_wdata;
            if (w_set_valid) begin
                r_valid[w_index] <= 1'b1;
            end
            if (w_set_dirty) begin
                r_dirty[w_index] <= 1'b1;
            end else if (w_clr_dirty) begin
                r_dirty[w_index] <= 1'b0;
            end
        end
    end

    // Tag and data arrays (no reset; guarded by valid)
    always_ff @(posedge clk) begin
        if (w_tag_we) begin
            r_tag[w_index] <= w_tag;
        end
        if (w_data_we) begin
            r_data[w_index] <= w_data_line;
        end
    end

    assign mem_resp     = r_mem_resp;
    assign mem_rdata    = r_mem_rdata;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

endmodule
